// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings,
// FSM state type and a mode classification helper.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHL   = 3'b001;
  localparam logic [2:0] MODE_SHR   = 3'b010;
  localparam logic [2:0] MODE_ASR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ROR   = 3'b101;
  localparam logic [2:0] MODE_LOAD  = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } usr_state_t;

  // Shift and rotate modes are the only ones that can be repeated as a burst.
  function automatic logic is_shift_mode(input logic [2:0] m);
    return (m >= MODE_SHL) && (m <= MODE_ROR);
  endfunction

endpackage

// File: rtl/usr_step_logic.sv
// Combinational next-value computation for one step of the shift register.
module usr_step_logic
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] r,
  input  logic             serial_in_left,
  input  logic             serial_in_right,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] next_r
);

  always_comb begin
    next_r = r;
    case (mode)
      MODE_SHL:   next_r = {r[WIDTH-2:0], serial_in_right};
      MODE_SHR:   next_r = {serial_in_left, r[WIDTH-1:1]};
      MODE_ASR:   next_r = {r[WIDTH-1], r[WIDTH-1:1]};
      MODE_ROL:   next_r = {r[WIDTH-2:0], r[WIDTH-1]};
      MODE_ROR:   next_r = {r[0], r[WIDTH-1:1]};
      MODE_LOAD:  next_r = parallel_in;
      MODE_CLEAR: next_r = '0;
      default:    next_r = r;
    endcase
  end

endmodule

// File: rtl/param_universal_shift_register.sv
// Universal shift register with single-step operation and a start-triggered
// burst engine that repeats one shift/rotate mode for burst_len enabled cycles.
module param_universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             serial_in_left,
  input  logic             serial_in_right,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out_left,
  output logic             serial_out_right,
  output logic             busy,
  output logic             done,
  output usr_state_t       fsm_state
);

  // Command handshake: start is taken only on an enabled edge while busy=0;
  // busy stays high until the last burst step, and done pulses for exactly
  // one cycle alongside the final register value of every accepted start.

  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] next_r;
  logic [CNT_W-1:0] remaining;
  logic [2:0]       latched_mode;
  logic [2:0]       step_mode;
  usr_state_t       state;

  assign step_mode = (state == ST_BURST) ? latched_mode : mode;

  usr_step_logic #(.WIDTH(WIDTH)) u_step (
    .mode            (step_mode),
    .r               (r),
    .serial_in_left  (serial_in_left),
    .serial_in_right (serial_in_right),
    .parallel_in     (parallel_in),
    .next_r          (next_r)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r            <= '0;
      remaining    <= '0;
      latched_mode <= MODE_HOLD;
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (en) begin
        case (state)
          ST_IDLE: begin
            if (!start) begin
              r <= next_r;
            end else if (is_shift_mode(mode)) begin
              // A zero-length burst performs no step but still completes.
              if (burst_len == '0) begin
                done <= 1'b1;
              end else begin
                r            <= next_r;
                latched_mode <= mode;
                if (burst_len == CNT_W'(1)) begin
                  done <= 1'b1;
                end else begin
                  state     <= ST_BURST;
                  busy      <= 1'b1;
                  remaining <= burst_len - CNT_W'(1);
                end
              end
            end else begin
              r    <= next_r;
              done <= 1'b1;
            end
          end
          ST_BURST: begin
            r         <= next_r;
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign parallel_out     = r;
  assign serial_out_left  = r[WIDTH-1];
  assign serial_out_right = r[0];
  assign fsm_state        = state;

endmodule

// File: tb/tb_param_universal_shift_register.sv
// Directed bench for param_universal_shift_register with hand-computed expectations.
module tb_param_universal_shift_register;
  import usr_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             reset_n;
  logic             en;
  logic [2:0]       mode;
  logic             serial_in_left;
  logic             serial_in_right;
  logic [WIDTH-1:0] parallel_in;
  logic             start;
  logic [CNT_W-1:0] burst_len;
  logic [WIDTH-1:0] parallel_out;
  logic             serial_out_left;
  logic             serial_out_right;
  logic             busy;
  logic             done;
  usr_state_t       fsm_state;

  int n_checks = 0;
  int n_errors = 0;

  param_universal_shift_register #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .en               (en),
    .mode             (mode),
    .serial_in_left   (serial_in_left),
    .serial_in_right  (serial_in_right),
    .parallel_in      (parallel_in),
    .start            (start),
    .burst_len        (burst_len),
    .parallel_out     (parallel_out),
    .serial_out_left  (serial_out_left),
    .serial_out_right (serial_out_right),
    .busy             (busy),
    .done             (done),
    .fsm_state        (fsm_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] m, input logic [WIDTH-1:0] pi);
    mode        = m;
    parallel_in = pi;
  endtask

  task automatic expect_state(input string tag, input logic [WIDTH-1:0] val,
                              input logic b, input logic d);
    check({tag, "_val"}, 32'(parallel_out), 32'(val));
    check({tag, "_busy"}, 32'(busy), 32'(b));
    check({tag, "_done"}, 32'(done), 32'(d));
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b1; mode = MODE_HOLD; serial_in_left = 1'b0;
    serial_in_right = 1'b0; parallel_in = '0; start = 1'b0; burst_len = '0;
    tick(); tick();
    expect_state("reset", 8'h00, 1'b0, 1'b0);
    check("reset_state", 32'(fsm_state), 32'(ST_IDLE));
    reset_n = 1'b1;

    // asynchronous reset between edges
    drive(MODE_LOAD, 8'hFF); tick();
    check("load_ff", 32'(parallel_out), 32'hFF);
    #2 reset_n = 1'b0;
    #1 expect_state("async_rst", 8'h00, 1'b0, 1'b0);
    #1 reset_n = 1'b1;

    // single-step modes
    drive(MODE_LOAD, 8'hA5); tick();
    check("load_a5", 32'(parallel_out), 32'hA5);
    drive(MODE_SHL, 8'h00); serial_in_right = 1'b1; tick();
    check("shl", 32'(parallel_out), 32'h4B);
    drive(MODE_SHR, 8'h00); serial_in_left = 1'b0; tick();
    check("shr", 32'(parallel_out), 32'h25);
    drive(MODE_LOAD, 8'h01); tick();
    drive(MODE_ROR, 8'h00); tick();
    check("ror", 32'(parallel_out), 32'h80);
    en = 1'b0; drive(MODE_LOAD, 8'h33); tick();
    check("en_hold", 32'(parallel_out), 32'h80);
    en = 1'b1;

    // ASR sign extension, then CLEAR
    drive(MODE_LOAD, 8'h80); tick();
    drive(MODE_ASR, 8'h00); tick();
    check("asr1", 32'(parallel_out), 32'hC0);
    tick();
    check("asr2", 32'(parallel_out), 32'hE0);
    tick();
    check("asr3", 32'(parallel_out), 32'hF0);
    check("sout_left", 32'(serial_out_left), 32'h1);
    check("sout_right", 32'(serial_out_right), 32'h0);
    drive(MODE_CLEAR, 8'h00); tick();
    check("clear", 32'(parallel_out), 32'h00);

    // ROL burst of 3, with a start issued while busy
    drive(MODE_LOAD, 8'h96); tick();
    drive(MODE_ROL, 8'h00); start = 1'b1; burst_len = 3; tick();
    expect_state("b1", 8'h2D, 1'b1, 1'b0);
    check("b1_state", 32'(fsm_state), 32'(ST_BURST));
    drive(MODE_LOAD, 8'h00); start = 1'b1; burst_len = 5; tick();
    expect_state("b2", 8'h5A, 1'b1, 1'b0);
    start = 1'b0; tick();
    expect_state("b3", 8'hB4, 1'b0, 1'b1);
    drive(MODE_HOLD, 8'h00); tick();
    expect_state("b4", 8'hB4, 1'b0, 1'b0);

    // same burst with a two-cycle stall after the first step
    drive(MODE_LOAD, 8'h96); tick();
    drive(MODE_ROL, 8'h00); start = 1'b1; burst_len = 3; tick();
    expect_state("s1", 8'h2D, 1'b1, 1'b0);
    start = 1'b0; en = 1'b0; drive(MODE_HOLD, 8'h00); tick();
    expect_state("s2", 8'h2D, 1'b1, 1'b0);
    tick();
    expect_state("s3", 8'h2D, 1'b1, 1'b0);
    en = 1'b1; tick();
    expect_state("s4", 8'h5A, 1'b1, 1'b0);
    tick();
    expect_state("s5", 8'hB4, 1'b0, 1'b1);
    tick();
    expect_state("s6", 8'hB4, 1'b0, 1'b0);

    // single-step burst completes from IDLE
    drive(MODE_ROR, 8'h00); start = 1'b1; burst_len = 1; tick();
    expect_state("n1", 8'h5A, 1'b0, 1'b1);
    start = 1'b0; drive(MODE_HOLD, 8'h00); tick();
    expect_state("n1_after", 8'h5A, 1'b0, 1'b0);

    // zero-length burst
    drive(MODE_SHR, 8'h00); serial_in_left = 1'b1; start = 1'b1; burst_len = 0; tick();
    expect_state("z1", 8'h5A, 1'b0, 1'b1);
    start = 1'b0; drive(MODE_HOLD, 8'h00); tick();
    expect_state("z2", 8'h5A, 1'b0, 1'b0);

    // reset in the middle of a SHL burst of 5
    drive(MODE_LOAD, 8'h01); tick();
    drive(MODE_SHL, 8'h00); serial_in_right = 1'b0; start = 1'b1; burst_len = 5; tick();
    expect_state("r1", 8'h02, 1'b1, 1'b0);
    start = 1'b0; tick();
    expect_state("r2", 8'h04, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1 expect_state("r_abort", 8'h00, 1'b0, 1'b0);
    #1 reset_n = 1'b1;
    drive(MODE_HOLD, 8'h00); tick();
    expect_state("r_after", 8'h00, 1'b0, 1'b0);
    check("r_after_state", 32'(fsm_state), 32'(ST_IDLE));

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
